// File: rtl/lc3_control_fsm_pkg.sv
// LC-3 microsequencer shared definitions: state numbers, opcodes, mux encodings,
// ALU function codes and the packed control word.
package lc3_ctrl_pkg;

  typedef enum logic [5:0] {
    S_BR     = 6'd0,
    S_ADD    = 6'd1,
    S_LD     = 6'd2,
    S_ST     = 6'd3,
    S_JSR    = 6'd4,
    S_AND    = 6'd5,
    S_LDR    = 6'd6,
    S_STR    = 6'd7,
    S_NOT    = 6'd9,
    S_LDI    = 6'd10,
    S_STI    = 6'd11,
    S_JMP    = 6'd12,
    S_LEA    = 6'd14,
    S_TRAP   = 6'd15,
    S_STW    = 6'd16,
    S_FETCH  = 6'd18,
    S_JSRR   = 6'd20,
    S_JSR11  = 6'd21,
    S_BRT    = 6'd22,
    S_STMDR  = 6'd23,
    S_LDIRD  = 6'd24,
    S_LDRD   = 6'd25,
    S_LDIMAR = 6'd26,
    S_LDWB   = 6'd27,
    S_TRAPRD = 6'd28,
    S_STIRD  = 6'd29,
    S_TRAPPC = 6'd30,
    S_STIMAR = 6'd31,
    S_DECODE = 6'd32,
    S_FRD    = 6'd33,
    S_FIR    = 6'd35,
    S_RST    = 6'd63
  } state_e;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RSV  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] PCMUX_BUS   = 2'b00;
  localparam logic [1:0] PCMUX_ADDER = 2'b01;
  localparam logic [1:0] PCMUX_INC   = 2'b10;

  localparam logic ADDR1_PC  = 1'b0;
  localparam logic ADDR1_SR1 = 1'b1;

  localparam logic [1:0] ADDR2_SEXT11 = 2'b00;
  localparam logic [1:0] ADDR2_SEXT9  = 2'b01;
  localparam logic [1:0] ADDR2_SEXT6  = 2'b10;
  localparam logic [1:0] ADDR2_ZERO   = 2'b11;

  localparam logic MARMUX_ZEXT8 = 1'b0;
  localparam logic MARMUX_ADDER = 1'b1;

  localparam logic DRMUX_IR11 = 1'b0;
  localparam logic DRMUX_R7   = 1'b1;

  localparam logic SR1MUX_IR11 = 1'b0;
  localparam logic SR1MUX_IR8  = 1'b1;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_reg;
    logic       ld_cc;
    logic       ld_pc;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic       marmux;
    logic       drmux;
    logic       sr1mux;
    logic [1:0] aluk;
    logic       mio_en;
    logic       r_w;
    logic       illegal;
  } ctrl_word_t;

endpackage

// File: rtl/lc3_control_fsm_if.sv
// Control/datapath boundary of the LC-3 microsequencer; master is the sequencer,
// slave is the datapath that supplies IR/BEN/MEM_R.
interface lc3_control_fsm_if #(
  parameter int unsigned STATE_W = 6
);
  logic [15:0]        IR;
  logic               BEN;
  logic               MEM_R;
  logic               LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC;
  logic               GATE_PC, GATE_MDR, GATE_ALU, GATE_MARMUX;
  logic [1:0]         PCMUX_SEL;
  logic               ADDR1MUX_SEL;
  logic [1:0]         ADDR2MUX_SEL;
  logic               MARMUX_SEL;
  logic               DRMUX_SEL;
  logic               SR1MUX_SEL;
  logic [1:0]         ALUK;
  logic               MIO_EN;
  logic               R_W;
  logic               ILLEGAL;
  logic [STATE_W-1:0] STATE;

  modport master (
    input  IR, BEN, MEM_R,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC,
           GATE_PC, GATE_MDR, GATE_ALU, GATE_MARMUX,
           PCMUX_SEL, ADDR1MUX_SEL, ADDR2MUX_SEL, MARMUX_SEL, DRMUX_SEL, SR1MUX_SEL,
           ALUK, MIO_EN, R_W, ILLEGAL, STATE
  );

  modport slave (
    output IR, BEN, MEM_R,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC,
           GATE_PC, GATE_MDR, GATE_ALU, GATE_MARMUX,
           PCMUX_SEL, ADDR1MUX_SEL, ADDR2MUX_SEL, MARMUX_SEL, DRMUX_SEL, SR1MUX_SEL,
           ALUK, MIO_EN, R_W, ILLEGAL, STATE
  );
endinterface

// File: rtl/lc3_control_fsm_outdec.sv
// Control-word decoder: current state -> datapath controls (Moore).
// LC3_CTRL_TRAP_EN enables the TRAP states; otherwise opcode 1111 decodes as illegal.
module lc3_ctrl_outdec
  import lc3_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [3:0] opcode_i,
  output ctrl_word_t ctrl_o
);

  logic op_illegal;

  always_comb begin
`ifdef LC3_CTRL_TRAP_EN
    op_illegal = (opcode_i == OP_RTI) || (opcode_i == OP_RSV);
`else
    op_illegal = (opcode_i == OP_RTI) || (opcode_i == OP_RSV) || (opcode_i == OP_TRAP);
`endif
  end

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.gate_pc = 1'b1;
        ctrl_o.ld_mar  = 1'b1;
        ctrl_o.ld_pc   = 1'b1;
        ctrl_o.pcmux   = PCMUX_INC;
      end
      S_FRD, S_LDIRD, S_LDRD, S_STIRD: begin
        ctrl_o.mio_en = 1'b1;
        ctrl_o.ld_mdr = 1'b1;
      end
      S_FIR: begin
        ctrl_o.gate_mdr = 1'b1;
        ctrl_o.ld_ir    = 1'b1;
      end
      // IR is a datapath register stable throughout DECODE, so this stays register-driven.
      S_DECODE: begin
        ctrl_o.ld_ben  = 1'b1;
        ctrl_o.illegal = op_illegal;
      end
      S_ADD, S_AND, S_NOT: begin
        ctrl_o.ld_reg   = 1'b1;
        ctrl_o.ld_cc    = 1'b1;
        ctrl_o.gate_alu = 1'b1;
        ctrl_o.drmux    = DRMUX_IR11;
        ctrl_o.sr1mux   = SR1MUX_IR8;
        ctrl_o.aluk     = (state_i == S_AND) ? ALUK_AND :
                          (state_i == S_NOT) ? ALUK_NOT : ALUK_ADD;
      end
      S_LEA: begin
        ctrl_o.addr1mux    = ADDR1_PC;
        ctrl_o.addr2mux    = ADDR2_SEXT9;
        ctrl_o.marmux      = MARMUX_ADDER;
        ctrl_o.gate_marmux = 1'b1;
        ctrl_o.ld_reg      = 1'b1;
        ctrl_o.ld_cc       = 1'b1;
      end
      S_LD, S_ST, S_LDI, S_STI: begin
        ctrl_o.addr1mux    = ADDR1_PC;
        ctrl_o.addr2mux    = ADDR2_SEXT9;
        ctrl_o.marmux      = MARMUX_ADDER;
        ctrl_o.gate_marmux = 1'b1;
        ctrl_o.ld_mar      = 1'b1;
      end
      S_LDR, S_STR: begin
        ctrl_o.addr1mux    = ADDR1_SR1;
        ctrl_o.addr2mux    = ADDR2_SEXT6;
        ctrl_o.sr1mux      = SR1MUX_IR8;
        ctrl_o.marmux      = MARMUX_ADDER;
        ctrl_o.gate_marmux = 1'b1;
        ctrl_o.ld_mar      = 1'b1;
      end
      S_LDIMAR, S_STIMAR: begin
        ctrl_o.gate_mdr = 1'b1;
        ctrl_o.ld_mar   = 1'b1;
      end
      S_LDWB: begin
        ctrl_o.gate_mdr = 1'b1;
        ctrl_o.ld_reg   = 1'b1;
        ctrl_o.ld_cc    = 1'b1;
        ctrl_o.drmux    = DRMUX_IR11;
      end
      S_STMDR: begin
        ctrl_o.sr1mux   = SR1MUX_IR11;
        ctrl_o.aluk     = ALUK_PASSA;
        ctrl_o.gate_alu = 1'b1;
        ctrl_o.ld_mdr   = 1'b1;
      end
      S_STW: begin
        ctrl_o.mio_en = 1'b1;
        ctrl_o.r_w    = 1'b1;
      end
      S_BRT: begin
        ctrl_o.ld_pc    = 1'b1;
        ctrl_o.pcmux    = PCMUX_ADDER;
        ctrl_o.addr1mux = ADDR1_PC;
        ctrl_o.addr2mux = ADDR2_SEXT9;
      end
      S_JMP: begin
        ctrl_o.ld_pc    = 1'b1;
        ctrl_o.pcmux    = PCMUX_ADDER;
        ctrl_o.addr1mux = ADDR1_SR1;
        ctrl_o.addr2mux = ADDR2_ZERO;
        ctrl_o.sr1mux   = SR1MUX_IR8;
      end
      S_JSRR, S_JSR11: begin
        ctrl_o.gate_pc  = 1'b1;
        ctrl_o.ld_reg   = 1'b1;
        ctrl_o.drmux    = DRMUX_R7;
        ctrl_o.ld_pc    = 1'b1;
        ctrl_o.pcmux    = PCMUX_ADDER;
        ctrl_o.sr1mux   = SR1MUX_IR8;
        ctrl_o.addr1mux = (state_i == S_JSRR) ? ADDR1_SR1 : ADDR1_PC;
        ctrl_o.addr2mux = (state_i == S_JSRR) ? ADDR2_ZERO : ADDR2_SEXT11;
      end
`ifdef LC3_CTRL_TRAP_EN
      S_TRAP: begin
        ctrl_o.marmux      = MARMUX_ZEXT8;
        ctrl_o.gate_marmux = 1'b1;
        ctrl_o.ld_mar      = 1'b1;
      end
      S_TRAPRD: begin
        ctrl_o.mio_en  = 1'b1;
        ctrl_o.ld_mdr  = 1'b1;
        ctrl_o.gate_pc = 1'b1;
        ctrl_o.ld_reg  = 1'b1;
        ctrl_o.drmux   = DRMUX_R7;
      end
      S_TRAPPC: begin
        ctrl_o.gate_mdr = 1'b1;
        ctrl_o.ld_pc    = 1'b1;
        ctrl_o.pcmux    = PCMUX_BUS;
      end
`endif
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/lc3_control_fsm.sv
// LC-3 microsequencer: state register + next-state logic; outputs come from lc3_ctrl_outdec.
// Optional macro LC3_CTRL_TRAP_EN enables TRAP states 15/28/30.
module lc3_control_fsm
  import lc3_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 6
) (
  input  logic              CLK,
  input  logic              RESET_N,
  lc3_control_fsm_if.master bus
);

  state_e     state_q, state_d;
  ctrl_word_t ctrl;

  always_ff @(posedge CLK) begin
    if (!RESET_N) state_q <= S_RST;
    else          state_q <= state_d;
  end

  // BR resolves in DECODE using the datapath's BEN, so state 0 is never entered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = S_FRD;
      S_FRD:    if (bus.MEM_R) state_d = S_FIR;
      S_FIR:    state_d = S_DECODE;
      S_DECODE: begin
        case (bus.IR[15:12])
          OP_ADD:  state_d = S_ADD;
          OP_AND:  state_d = S_AND;
          OP_NOT:  state_d = S_NOT;
          OP_LEA:  state_d = S_LEA;
          OP_LD:   state_d = S_LD;
          OP_LDR:  state_d = S_LDR;
          OP_LDI:  state_d = S_LDI;
          OP_ST:   state_d = S_ST;
          OP_STR:  state_d = S_STR;
          OP_STI:  state_d = S_STI;
          OP_BR:   state_d = bus.BEN ? S_BRT : S_FETCH;
          OP_JMP:  state_d = S_JMP;
          OP_JSR:  state_d = S_JSR;
`ifdef LC3_CTRL_TRAP_EN
          OP_TRAP: state_d = S_TRAP;
`endif
          default: state_d = S_FETCH;
        endcase
      end
      S_JSR:    state_d = bus.IR[11] ? S_JSR11 : S_JSRR;
      S_LD, S_LDR: state_d = S_LDRD;
      S_LDI:    state_d = S_LDIRD;
      S_LDIRD:  if (bus.MEM_R) state_d = S_LDIMAR;
      S_LDIMAR: state_d = S_LDRD;
      S_LDRD:   if (bus.MEM_R) state_d = S_LDWB;
      S_ST, S_STR: state_d = S_STMDR;
      S_STI:    state_d = S_STIRD;
      S_STIRD:  if (bus.MEM_R) state_d = S_STIMAR;
      S_STIMAR: state_d = S_STMDR;
      S_STMDR:  state_d = S_STW;
      S_STW:    if (bus.MEM_R) state_d = S_FETCH;
`ifdef LC3_CTRL_TRAP_EN
      S_TRAP:   state_d = S_TRAPRD;
      S_TRAPRD: if (bus.MEM_R) state_d = S_TRAPPC;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  lc3_ctrl_outdec u_outdec (
    .state_i  (state_q),
    .opcode_i (bus.IR[15:12]),
    .ctrl_o   (ctrl)
  );

  assign bus.LD_MAR       = ctrl.ld_mar;
  assign bus.LD_MDR       = ctrl.ld_mdr;
  assign bus.LD_IR        = ctrl.ld_ir;
  assign bus.LD_BEN       = ctrl.ld_ben;
  assign bus.LD_REG       = ctrl.ld_reg;
  assign bus.LD_CC        = ctrl.ld_cc;
  assign bus.LD_PC        = ctrl.ld_pc;
  assign bus.GATE_PC      = ctrl.gate_pc;
  assign bus.GATE_MDR     = ctrl.gate_mdr;
  assign bus.GATE_ALU     = ctrl.gate_alu;
  assign bus.GATE_MARMUX  = ctrl.gate_marmux;
  assign bus.PCMUX_SEL    = ctrl.pcmux;
  assign bus.ADDR1MUX_SEL = ctrl.addr1mux;
  assign bus.ADDR2MUX_SEL = ctrl.addr2mux;
  assign bus.MARMUX_SEL   = ctrl.marmux;
  assign bus.DRMUX_SEL    = ctrl.drmux;
  assign bus.SR1MUX_SEL   = ctrl.sr1mux;
  assign bus.ALUK         = ctrl.aluk;
  assign bus.MIO_EN       = ctrl.mio_en;
  assign bus.R_W          = ctrl.r_w;
  assign bus.ILLEGAL      = ctrl.illegal;
  assign bus.STATE        = STATE_W'(state_q);

endmodule
